sram_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller that uses the 64x8 two-port SRAM macro (S65NLLHS2PH64x8: port A read, port B write) as its storage array.
- Converts valid/ready push and pop streams into macro port-A read cycles and port-B write cycles.
- Hides the macro's 1-cycle read latency with a 2-entry output buffer, giving first-word-fall-through pop data at 1 word/cycle.
- Sits between a producer and a consumer; the macro is instantiated beside it and driven only by this block.

---
 rtl/sram_fifo_ctrl.sv | 109 ++++++++++
 tb/tb_sram_fifo_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl
//   FIFO controller in front of a 64x8 two-port SRAM macro (port A read,
//   port B write). Push/pop valid/ready streams become macro write and read
//   cycles. A 2-entry output buffer hides the macro's 1-cycle read latency,
//   so pop data is first-word-fall-through at one word per cycle.
//
// Ports
//   CLK, RST              clock, synchronous active-high reset
//   push_valid/ready/data producer stream
//   pop_valid/ready/data  consumer stream (pop_data = FIFO head)
//   count                 total words held, 0..DEPTH+2
//   CENA, AA, QA          macro read port (QA valid the cycle after the edge)
//   CENB, BWENB, AB, DB   macro write port (active-low enables)
module sram_fifo_ctrl #(
  parameter int BITS   = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [BITS-1:0]   push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [BITS-1:0]   pop_data,
  output logic [ADDR_W:0]   count,
  output logic              CENA,
  output logic [ADDR_W-1:0] AA,
  input  logic [BITS-1:0]   QA,
  output logic              CENB,
  output logic [BITS-1:0]   BWENB,
  output logic [ADDR_W-1:0] AB,
  output logic [BITS-1:0]   DB
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0]       wptr_q, wptr_d;
  logic [ADDR_W-1:0]       rptr_q, rptr_d;
  logic [ADDR_W:0]         mem_cnt_q, mem_cnt_d;
  logic                    rd_inflight_q, rd_inflight_d;
  logic [1:0]              ob_cnt_q, ob_cnt_d;
  logic [1:0][BITS-1:0]    ob_q, ob_d;

  logic                    push_fire, pop_fire, rd_issue;
  logic [2:0]              occ;
  logic [1:0]              ob_tail;

  always_comb begin
    push_ready = ~RST & (mem_cnt_q != DEPTH_C);
    pop_valid  = (ob_cnt_q != 2'd0);
    push_fire  = push_valid & push_ready;
    pop_fire   = pop_valid & pop_ready;

    // Buffer occupancy including the word already on its way from the macro.
    // A new read may only go out if that word plus this one still fit after
    // this cycle's pop, so the 2-entry buffer can never overflow.
    occ      = {1'b0, ob_cnt_q} + {2'b0, rd_inflight_q};
    rd_issue = ~RST & (mem_cnt_q != '0) & (occ < (pop_fire ? 3'd3 : 3'd2));

    // Pointers wrap naturally because DEPTH is a power of two.
    wptr_d        = wptr_q + ADDR_W'(push_fire);
    rptr_d        = rptr_q + ADDR_W'(rd_issue);
    mem_cnt_d     = mem_cnt_q + (ADDR_W+1)'(push_fire) - (ADDR_W+1)'(rd_issue);
    rd_inflight_d = rd_issue;

    // Pop shifts first; the returning read word then lands in the new tail.
    ob_d    = ob_q;
    ob_tail = ob_cnt_q;
    if (pop_fire) begin
      ob_d[0] = ob_q[1];
      ob_tail = ob_cnt_q - 2'd1;
    end
    if (rd_inflight_q) begin
      ob_d[ob_tail[0]] = QA;
      ob_tail          = ob_tail + 2'd1;
    end
    ob_cnt_d = ob_tail;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      mem_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;   // drops any read issued before reset
      ob_cnt_q      <= '0;
      ob_q          <= '0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      mem_cnt_q     <= mem_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      ob_cnt_q      <= ob_cnt_d;
      ob_q          <= ob_d;
    end
  end

  assign CENA     = ~rd_issue;
  assign AA       = rptr_q;
  assign CENB     = ~push_fire;
  assign BWENB    = push_fire ? '0 : '1;
  assign AB       = wptr_q;
  assign DB       = push_data;
  assign pop_data = ob_q[0];
  assign count    = mem_cnt_q + (ADDR_W+1)'(rd_inflight_q) + (ADDR_W+1)'(ob_cnt_q);

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: behavioural model of the 64x8 macro, scoreboard
// queue of accepted pushes, and an always-on monitor checking pops, count,
// and macro port activity against bench-side counters.
module tb_sram_fifo_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       push_valid, pop_ready;
  logic [7:0] push_data;
  logic       push_ready, pop_valid;
  logic [7:0] pop_data;
  logic [6:0] count;
  logic       CENA, CENB;
  logic [5:0] AA, AB;
  logic [7:0] QA, BWENB, DB;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  sram_fifo_ctrl dut (
    .CLK(CLK), .RST(RST),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .count(count),
    .CENA(CENA), .AA(AA), .QA(QA),
    .CENB(CENB), .BWENB(BWENB), .AB(AB), .DB(DB)
  );

  // Macro model: write with per-bit enables, registered read data.
  logic [7:0] mem [64];
  initial QA = 8'h00;
  always @(posedge CLK) begin
    if (!CENB)
      for (int b = 0; b < 8; b++)
        if (!BWENB[b]) mem[AB][b] <= DB[b];
    if (!CENA) QA <= mem[AA];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Scoreboard and macro-op counters
  logic [7:0] sb [$];
  int wr_n = 0;
  int rd_n = 0;

  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      chk("rst_count", 32'(count), 32'(sb.size()));
      chk("rst_cena", 32'(CENA), 32'd1);
      chk("rst_cenb", 32'(CENB), 32'd1);
      sb.delete();
      wr_n = 0;
      rd_n = 0;
    end else if (RST === 1'b0) begin
      chk("count", 32'(count), 32'(sb.size()));
      chk("cenb", 32'(CENB), 32'(!(push_valid && push_ready)));
      if (!CENA) begin
        // never read a word that has not been written yet
        chk("rd_avail", 32'(wr_n > rd_n), 32'd1);
        chk("aa", 32'(AA), 32'(rd_n % 64));
        rd_n++;
      end
      if (!CENB) begin
        chk("ab", 32'(AB), 32'(wr_n % 64));
        chk("db", 32'(DB), 32'(push_data));
        chk("bwenb", 32'(BWENB), 32'h00);
        wr_n++;
      end else begin
        chk("bwenb_idle", 32'(BWENB), 32'hff);
      end
      if (pop_valid && pop_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk("pop_data", 32'(pop_data), 32'(sb.pop_front()));
      end
      if (push_valid && push_ready) sb.push_back(push_data);
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic drain();
    bit done = 0;
    push_valid = 0;
    pop_ready  = 1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge CLK);
      if (count == 0) done = 1;
      tick();
    end
    chk("drain_empty", 32'(done), 32'd1);
    pop_ready = 0;
  endtask

  initial begin
    int  n;
    bit  f;
    bit  got;

    RST = 1; push_valid = 0; pop_ready = 0; push_data = 8'h5A;
    @(negedge CLK);
    chk("rst_push_ready", 32'(push_ready), 32'd0);
    tick(); tick();
    RST = 0;

    // Reset values
    @(negedge CLK);
    chk("r_pop_valid", 32'(pop_valid), 32'd0);
    chk("r_pop_data", 32'(pop_data), 32'd0);
    chk("r_count", 32'(count), 32'd0);
    chk("r_cena", 32'(CENA), 32'd1);
    chk("r_aa", 32'(AA), 32'd0);
    chk("r_ab", 32'(AB), 32'd0);
    chk("r_db", 32'(DB), 32'h5A);
    chk("r_push_ready", 32'(push_ready), 32'd1);

    // Single word, latency to pop_valid
    tick();
    push_valid = 1; push_data = 8'hA5;
    @(negedge CLK);
    chk("w_cenb", 32'(CENB), 32'd0);
    chk("w_bwenb", 32'(BWENB), 32'h00);
    chk("w_db", 32'(DB), 32'hA5);
    tick();                 // E0
    push_valid = 0;
    @(negedge CLK);
    chk("lat_e0", 32'(pop_valid), 32'd0);
    tick();                 // E1
    @(negedge CLK);
    chk("lat_e1", 32'(pop_valid), 32'd0);
    tick();                 // E2
    @(negedge CLK);
    chk("lat_e2", 32'(pop_valid), 32'd1);
    chk("lat_data", 32'(pop_data), 32'hA5);
    chk("lat_count", 32'(count), 32'd1);
    tick();
    pop_ready = 1;
    tick();
    pop_ready = 0;
    @(negedge CLK);
    chk("pop1_count", 32'(count), 32'd0);
    chk("pop1_valid", 32'(pop_valid), 32'd0);
    tick();

    // Fill to 66
    n = 0;
    push_valid = 1;
    for (int c = 0; c < 200 && n < 66; c++) begin
      push_data = 8'(n);
      @(negedge CLK);
      f = push_ready;
      tick();
      if (f) n++;
    end
    chk("fill_n", 32'(n), 32'd66);
    push_data = 8'hEE;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("full_ready", 32'(push_ready), 32'd0);
      chk("full_count", 32'(count), 32'd66);
      tick();
    end
    push_valid = 0;

    // Drain with no bubbles, AA wraps
    pop_ready = 1;
    for (int i = 0; i < 66; i++) begin
      @(negedge CLK);
      chk("drain_valid", 32'(pop_valid), 32'd1);
      tick();
    end
    pop_ready = 0;
    @(negedge CLK);
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_pv", 32'(pop_valid), 32'd0);
    tick();

    // Streaming
    push_valid = 1; pop_ready = 1;
    for (int i = 0; i < 200; i++) begin
      push_data = 8'(i);
      @(negedge CLK);
      if (i >= 3) begin
        chk("stream_count", 32'(count), 32'd3);
        chk("stream_pv", 32'(pop_valid), 32'd1);
      end
      tick();
    end
    drain();

    // Random back-pressure
    for (int i = 0; i < 1000; i++) begin
      push_valid = 1'($urandom_range(0, 1));
      pop_ready  = 1'($urandom_range(0, 1));
      push_data  = 8'($urandom);
      @(negedge CLK);
      tick();
    end
    drain();

    // Reset with count=30 and a read in flight
    push_valid = 1;
    for (int i = 0; i < 31; i++) begin
      push_data = 8'(8'h80 + i);
      tick();
    end
    push_valid = 0;
    tick(); tick(); tick();
    pop_ready = 1;
    @(negedge CLK);
    chk("pre_count", 32'(count), 32'd31);
    chk("pre_cena", 32'(CENA), 32'd0);
    tick();
    pop_ready = 0; RST = 1;
    @(negedge CLK);
    chk("mid_count", 32'(count), 32'd30);
    chk("mid_ready", 32'(push_ready), 32'd0);
    chk("mid_cena", 32'(CENA), 32'd1);
    tick();
    RST = 0;
    @(negedge CLK);
    chk("post_count", 32'(count), 32'd0);
    chk("post_pv", 32'(pop_valid), 32'd0);
    tick();
    push_valid = 1; push_data = 8'h3C;
    tick();
    push_valid = 0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge CLK);
      if (pop_valid) got = 1;
      else tick();
    end
    chk("post_wait", 32'(got), 32'd1);
    chk("post_data", 32'(pop_data), 32'h3C);
    tick();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
